imm_encoder: RTL and testbench

- Inverse of the datapath immediate generator. Accepts decoded instruction fields plus a 32-bit signed immediate and an ImmSel-style format code.
- Scatters the immediate into RV32I instruction bit positions and emits the assembled 32-bit instruction word.
- Buffered in a small FIFO with valid/ready handshakes on both sides.
- Used by the instruction-memory loader and the self-check testbench to build program images.

---
 rtl/imm_encoder_pkg.sv | 23 ++
 rtl/imm_encoder_if.sv | 29 ++
 rtl/imm_encoder_fmt_pack.sv | 56 +++++
 rtl/imm_encoder.sv | 101 ++++++++++
 tb/tb_imm_encoder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format codes that mirror the
// immediate generator's select encoding, the NOP word, and a range-check helper.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when v[31:msb] are all equal, i.e. v fits a signed field whose sign bit is msb.
    function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned msb);
        logic signed [31:0] s;
        s = v >>> msb;
        return (&s) || (~|s);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Field-bundle input and instruction-word output handshakes of the immediate encoder.
interface imm_encoder_if;
    logic               in_valid;
    logic               in_ready;
    logic        [2:0]  in_sel;
    logic        [6:0]  in_opcode;
    logic        [2:0]  in_funct3;
    logic        [6:0]  in_funct7;
    logic        [4:0]  in_rd;
    logic        [4:0]  in_rs1;
    logic        [4:0]  in_rs2;
    logic signed [31:0] in_imm;
    logic               out_valid;
    logic               out_ready;
    logic        [31:0] out_instr;
    logic               out_err;

    modport master (
        output in_valid, in_sel, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_sel, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/imm_encoder_fmt_pack.sv
// Combinational RV32I field packer with immediate range check.
// Define IMM_UJ_EN to enable the U and J formats; otherwise they encode as NOP with error.
module imm_fmt_pack
    import imm_encoder_pkg::*;
(
    input  logic        [2:0]  sel,
    input  logic        [6:0]  opcode,
    input  logic        [2:0]  funct3,
    input  logic        [6:0]  funct7,
    input  logic        [4:0]  rd,
    input  logic        [4:0]  rs1,
    input  logic        [4:0]  rs2,
    input  logic signed [31:0] imm,
    output logic        [31:0] word,
    output logic               err
);

    always_comb begin
        word = NOP_WORD;
        err  = 1'b1;
        case (sel)
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
                err  = 1'b0;
            end
            FMT_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                err  = ~fits_signed(imm, 11);
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = ~fits_signed(imm, 11);
            end
            // Branch offsets are halfword aligned; bit 0 has no slot in the word.
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = ~fits_signed(imm, 12) | imm[0];
            end
`ifdef IMM_UJ_EN
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                err  = |imm[11:0];
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = ~fits_signed(imm, 20) | imm[0];
            end
`endif
            default: begin
                word = NOP_WORD;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: packs field bundles into RV32I words and queues them
// in a DEPTH-entry FIFO with saturating accept/error statistics.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

    logic [31:0]    word_p0;
    logic           err_p0;
    logic           vld_p0;
    logic [31:0]    instr_p1 [DEPTH];
    logic [DEPTH-1:0] err_p1;
    logic [31:0]    last_instr_p2;
    logic           last_err_p2;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           pop;

    // Stage p0: combinational packing of the presented bundle
    imm_fmt_pack u_pack (
        .sel    (bus.in_sel),
        .opcode (bus.in_opcode),
        .funct3 (bus.in_funct3),
        .funct7 (bus.in_funct7),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .imm    (bus.in_imm),
        .word   (word_p0),
        .err    (err_p0)
    );

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign vld_p0        = bus.in_valid & ~full;
    assign pop           = ~empty & bus.out_ready;

    // Stage p1: FIFO storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            instr_p1[wr_ptr] <= word_p0;
            err_p1[wr_ptr]   <= err_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (vld_p0) begin
                wr_ptr    <= wr_ptr + AW'(1);
                enc_count <= sat_inc(enc_count);
                if (err_p0) err_count <= sat_inc(err_count);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (vld_p0 && !pop)      count <= count + CW'(1);
            else if (pop && !vld_p0) count <= count - CW'(1);
        end
    end

    // Stage p2: remember the last head so the outputs hold once the FIFO drains
    always_ff @(posedge clk) begin
        if (rst) begin
            last_instr_p2 <= '0;
            last_err_p2   <= 1'b0;
        end else if (pop) begin
            last_instr_p2 <= instr_p1[rd_ptr];
            last_err_p2   <= err_p1[rd_ptr];
        end
    end

    assign bus.out_instr = empty ? last_instr_p2 : instr_p1[rd_ptr];
    assign bus.out_err   = empty ? last_err_p2   : err_p1[rd_ptr];

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: encoding vectors, FIFO flow control, reset and counters.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
`ifdef IMM_UJ_EN
    localparam bit UJ = 1'b1;
`else
    localparam bit UJ = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;
    int vectors = 0;
    int miscompares = 0;
    int exp_enc = 0;
    int exp_err = 0;

    imm_encoder_if bus ();

    imm_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] sel, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [31:0] word, input logic err);
        vec_t v;
        v = '{sel, op, f3, f7, rd, rs1, rs2, imm, word, err};
        return v;
    endfunction

    // Plain I-type word used for FIFO ordering tests: addi xk, x0, k.
    function automatic vec_t seq_vec(input int k);
        logic [31:0] w;
        w = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
        return mk(3'd1, 7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k), w, 1'b0);
    endfunction

    task automatic drive(input vec_t v);
        bus.in_sel    = v.sel;
        bus.in_opcode = v.op;
        bus.in_funct3 = v.f3;
        bus.in_funct7 = v.f7;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_imm    = v.imm;
    endtask

    task automatic push(input vec_t v);
        drive(v);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_enc = (exp_enc == SAT) ? SAT : exp_enc + 1;
        if (v.err) exp_err = (exp_err == SAT) ? SAT : exp_err + 1;
    endtask

    task automatic pop1();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_enc = 0;
        exp_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
        vectors++; if (bus.out_err !== 1'b0) begin miscompares++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
        vectors++; if (enc_count !== '0 || err_count !== '0) begin miscompares++; $display("FAIL reset_counts: got %0d/%0d want 0/0", enc_count, err_count); end
    endtask

    task automatic run_table(input string tag, input vec_t tbl[], input int n);
        for (int i = 0; i < n; i++) begin
            push(tbl[i]);
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid[%0d]: got %b want 1", tag, i, bus.out_valid); end
            vectors++; if (bus.out_instr !== tbl[i].word) begin miscompares++; $display("FAIL %s_instr[%0d]: got %h want %h", tag, i, bus.out_instr, tbl[i].word); end
            vectors++; if (bus.out_err !== tbl[i].err) begin miscompares++; $display("FAIL %s_err[%0d]: got %b want %b", tag, i, bus.out_err, tbl[i].err); end
            vectors++; if (enc_count !== CNT_W'(exp_enc) || err_count !== CNT_W'(exp_err)) begin miscompares++; $display("FAIL %s_counts[%0d]: got %0d/%0d want %0d/%0d", tag, i, enc_count, err_count, exp_enc, exp_err); end
            pop1();
            vectors++; if (bus.out_valid !== 1'b0 || bus.out_instr !== tbl[i].word) begin miscompares++; $display("FAIL %s_hold[%0d]: got v=%b %h want v=0 %h", tag, i, bus.out_valid, bus.out_instr, tbl[i].word); end
        end
    endtask

    task automatic test_encode();
        vec_t tbl[];
        tbl = new[9];
        tbl[0] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
        tbl[1] = mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'h0000_0008, 32'h0051_2423, 1'b0);
        tbl[2] = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        tbl[3] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0013, 1'b1);
        tbl[4] = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0006, 32'h0000_0363, 1'b0);
        tbl[5] = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0005, 32'h0000_0263, 1'b1);
        tbl[6] = mk(3'd7, 7'h33, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0000_0004, 32'h0000_0013, 1'b1);
        tbl[7] = mk(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'h4031_00B3, 1'b0);
        tbl[8] = mk(3'd2, 7'h23, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0023, 1'b0);
        run_table("enc", tbl, 9);
    endtask

    task automatic test_uj();
        vec_t tbl[];
        tbl = new[5];
        tbl[0] = mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h1234_5000, UJ ? 32'h1234_50B7 : NOP_WORD, !UJ);
        tbl[1] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0008, UJ ? 32'h0080_00EF : NOP_WORD, !UJ);
        tbl[2] = mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h1234_5001, UJ ? 32'h1234_50B7 : NOP_WORD, 1'b1);
        tbl[3] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000, UJ ? 32'h8000_00EF : NOP_WORD, 1'b1);
        tbl[4] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFE, UJ ? 32'hFFFF_F0EF : NOP_WORD, !UJ);
        run_table("uj", tbl, 5);
    endtask

    task automatic test_fifo_full();
        vec_t v;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push(seq_vec(k));
            vectors++; if (bus.in_ready !== (k < 4)) begin miscompares++; $display("FAIL full_in_ready[%0d]: got %b want %b", k, bus.in_ready, (k < 4)); end
        end
        // Fifth bundle presented while full must be held off.
        v = seq_vec(5);
        drive(v);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0 || enc_count !== CNT_W'(exp_enc)) begin miscompares++; $display("FAIL full_hold: got rdy=%b cnt=%0d want rdy=0 cnt=%0d", bus.in_ready, enc_count, exp_enc); end
        vectors++; if (bus.out_instr !== seq_vec(1).word) begin miscompares++; $display("FAIL full_head: got %h want %h", bus.out_instr, seq_vec(1).word); end
        // Push and pop together at full: only the pop lands.
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++; if (bus.in_ready !== 1'b1 || enc_count !== CNT_W'(exp_enc)) begin miscompares++; $display("FAIL full_pushpop: got rdy=%b cnt=%0d want rdy=1 cnt=%0d", bus.in_ready, enc_count, exp_enc); end
        for (int k = 2; k <= 4; k++) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_instr !== seq_vec(k).word) begin miscompares++; $display("FAIL drain[%0d]: got v=%b %h want v=1 %h", k, bus.out_valid, bus.out_instr, seq_vec(k).word); end
            pop1();
        end
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_instr !== seq_vec(4).word) begin miscompares++; $display("FAIL drain_empty: got v=%b %h want v=0 %h", bus.out_valid, bus.out_instr, seq_vec(4).word); end
    endtask

    task automatic test_back_to_back();
        push(seq_vec(9));
        drive(seq_vec(10));
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_enc = (exp_enc == SAT) ? SAT : exp_enc + 1;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_instr !== seq_vec(10).word) begin miscompares++; $display("FAIL b2b_head: got v=%b %h want v=1 %h", bus.out_valid, bus.out_instr, seq_vec(10).word); end
        vectors++; if (enc_count !== CNT_W'(exp_enc)) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", enc_count, exp_enc); end
        pop1();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_midflight();
        for (int k = 1; k <= 3; k++) push(seq_vec(k + 20));
        do_reset();
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_flags: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
        vectors++; if (enc_count !== '0 || err_count !== '0) begin miscompares++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", enc_count, err_count); end
        vectors++; if (bus.out_instr !== 32'h0 || bus.out_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_out: got %h/%b want 0/0", bus.out_instr, bus.out_err); end
        push(seq_vec(7));
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_instr !== seq_vec(7).word) begin miscompares++; $display("FAIL mid_rst_after: got v=%b %h want v=1 %h", bus.out_valid, bus.out_instr, seq_vec(7).word); end
        pop1();
    endtask

    task automatic test_saturation();
        vec_t v;
        do_reset();
        v = mk(3'd7, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, NOP_WORD, 1'b1);
        drive(v);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++; if (int'(enc_count) !== ((i + 1 > SAT) ? SAT : i + 1)) begin miscompares++; $display("FAIL sat_enc[%0d]: got %0d want %0d", i, enc_count, (i + 1 > SAT) ? SAT : i + 1); end
        end
        bus.in_valid  = 1'b0;
        vectors++; if (err_count !== CNT_W'(SAT)) begin miscompares++; $display("FAIL sat_err: got %0d want %0d", err_count, SAT); end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL sat_drain: got %b want 0", bus.out_valid); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(mk(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_encode();
        test_uj();
        do_reset();
        test_fifo_full();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
